// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache: boolean constants,
// default geometry and the miss-handling state encoding.
package icache_direct_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int ICACHE_INDEX_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

endpackage

// File: rtl/icache_direct_store.sv
// Line storage for the instruction cache: valid/tag/data arrays with an
// asynchronous read port and a synchronous write port.
module icache_direct_store
  import icache_direct_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int TAG_WIDTH   = 22,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output logic                   rd_valid,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [DATA_W-1:0]      rd_data,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [DATA_W-1:0]      wr_data
);

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [LINES-1:0]     valid;
  logic [TAG_WIDTH-1:0] tag_mem  [LINES];
  logic [DATA_W-1:0]    data_mem [LINES];

  // Only the valid bits are reset; tag/data contents are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= TRUE;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache. Hits return combinationally;
// a miss issues one word request to the memory controller and fills on its response.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  input  logic                  clear,
  output logic                  hit,
  output logic [31:0]           inst,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_enable,
  input  logic [31:0]           mem_din
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   miss_addr;
  logic                    rd_valid;
  logic [TAG_WIDTH-1:0]    rd_tag;
  logic [31:0]             rd_data;
  logic                    fill_we;
  logic                    unused_low_bits;

  wire [INDEX_WIDTH-1:0] pc_idx   = fetch_pc[INDEX_WIDTH+1:2];
  wire [TAG_WIDTH-1:0]   pc_tag   = fetch_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  wire [INDEX_WIDTH-1:0] miss_idx = miss_addr[INDEX_WIDTH+1:2];
  wire [TAG_WIDTH-1:0]   miss_tag = miss_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];

  assign unused_low_bits = ^{fetch_pc[1:0], miss_addr[1:0]};

  // Fill always targets the latched miss address, even when clear arrives with the data.
  assign fill_we = !rst && rdy && (state == MISS) && mem_enable;

  icache_direct_store #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH),
    .DATA_W      (32)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (fill_we),
    .wr_idx   (miss_idx),
    .wr_tag   (miss_tag),
    .wr_data  (mem_din)
  );

  always_comb begin
    hit = FALSE;
    if (rdy && fetch_valid && rd_valid && (rd_tag == pc_tag)) begin
      hit = TRUE;
    end
  end

  assign inst = rd_data;

  // Combinational drop on the response/clear cycle keeps the controller from re-issuing;
  // while paused the request is held as-is.
  assign mem_valid = (state == MISS) && !(rdy && (mem_enable || clear));
  assign mem_addr  = miss_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (fetch_valid && !hit && !clear) begin
            state     <= MISS;
            miss_addr <= {fetch_pc[ADDR_WIDTH-1:2], 2'b00};
          end
        end
        MISS: begin
          if (mem_enable || clear) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed vector table followed by
// randomized traffic compared against a line-level behavioural cache model.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        clear;
  logic        hit;
  logic [31:0] inst;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_enable;
  logic [31:0] mem_din;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  icache_direct #(
    .INDEX_WIDTH (8),
    .ADDR_WIDTH  (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .clear       (clear),
    .hit         (hit),
    .inst        (inst),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_enable  (mem_enable),
    .mem_din     (mem_din)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        fv;
    logic        clr;
    logic        men;
    logic [31:0] pc;
    logic [31:0] din;
    logic        chk;
    logic        e_hit;
    logic [31:0] e_inst;
    logic        e_mv;
    logic        chk_ma;
    logic [31:0] e_ma;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic rd, input logic fv, input logic clr,
                     input logic men, input logic [31:0] pc, input logic [31:0] din,
                     input logic chk, input logic eh, input logic [31:0] ei,
                     input logic emv, input logic cma, input logic [31:0] ema);
    vec_t v;
    v.rst = r; v.rdy = rd; v.fv = fv; v.clr = clr; v.men = men; v.pc = pc; v.din = din;
    v.chk = chk; v.e_hit = eh; v.e_inst = ei; v.e_mv = emv; v.chk_ma = cma; v.e_ma = ema;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic rd, input logic fv, input logic clr,
                       input logic men, input logic [31:0] pc, input logic [31:0] din);
    rst = r; rdy = rd; fetch_valid = fv; clear = clr;
    mem_enable = men; fetch_pc = pc; mem_din = din;
  endtask

  // Reference model: each line remembers the full word address it holds.
  bit          m_v [256];
  logic [29:0] m_w [256];
  logic [31:0] m_d [256];
  bit          m_pend;
  logic [31:0] m_pa;
  int          m_lat;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_v[i] = 0;
    m_pend = 0;
    m_pa = 32'h0;
    m_lat = 0;
  endtask

  logic [31:0] pcs [8] = '{32'h004, 32'h404, 32'h804, 32'h008, 32'h100, 32'h200, 32'h1204, 32'h3F0};

  initial begin
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // cold miss: rst, pc 0x004
    add(1,1,0,0,0, 32'h004, 0,            0, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h004, 0,            1, 0,0,            0,1,32'h0);
    add(0,1,1,0,0, 32'h004, 0,            1, 0,0,            1,1,32'h004);
    add(0,1,1,0,1, 32'h004, 32'h00A00093, 1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h004, 0,            1, 1,32'h00A00093, 0,0,0);
    // conflict: 0x404 evicts, then 0x004 refetched
    add(0,1,1,0,0, 32'h404, 0,            1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h404, 0,            1, 0,0,            1,1,32'h404);
    add(0,1,1,0,1, 32'h404, 32'h22222222, 1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h404, 0,            1, 1,32'h22222222, 0,0,0);
    add(0,1,1,0,0, 32'h404, 0,            1, 1,32'h22222222, 0,0,0);
    add(0,1,1,0,0, 32'h004, 0,            1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h004, 0,            1, 0,0,            1,1,32'h004);
    add(0,1,1,0,1, 32'h004, 32'h11111111, 1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h004, 0,            1, 1,32'h11111111, 0,0,0);
    add(0,1,1,1,0, 32'h404, 0,            1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h006, 0,            1, 1,32'h11111111, 0,0,0);
    // flush mid-miss on 0x100
    add(0,1,1,0,0, 32'h100, 0,            1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h100, 0,            1, 0,0,            1,1,32'h100);
    add(0,1,1,0,0, 32'h100, 0,            1, 0,0,            1,1,32'h100);
    add(0,1,1,1,0, 32'h100, 0,            1, 0,0,            0,0,0);
    add(0,1,0,0,0, 32'h100, 0,            1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h100, 0,            1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h100, 0,            1, 0,0,            1,1,32'h100);
    add(0,1,1,1,0, 32'h100, 0,            1, 0,0,            0,0,0);
    // clear together with mem_enable on 0x200
    add(0,1,1,0,0, 32'h200, 0,            1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h200, 0,            1, 0,0,            1,1,32'h200);
    add(0,1,1,1,1, 32'h200, 32'hDEADBEEF, 1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h200, 0,            1, 1,32'hDEADBEEF, 0,0,0);
    add(0,1,1,0,0, 32'h200, 0,            1, 1,32'hDEADBEEF, 0,0,0);
    // pause during miss on 0x300
    add(0,1,1,0,0, 32'h300, 0,            1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h300, 0,            1, 0,0,            1,1,32'h300);
    add(0,0,1,0,0, 32'h300, 0,            1, 0,0,            1,1,32'h300);
    add(0,0,1,0,0, 32'h300, 0,            1, 0,0,            1,1,32'h300);
    add(0,0,1,0,0, 32'h300, 0,            1, 0,0,            1,1,32'h300);
    add(0,1,1,0,1, 32'h300, 32'h33333333, 1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h300, 0,            1, 1,32'h33333333, 0,0,0);
    add(0,0,1,0,0, 32'h200, 0,            1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h200, 0,            1, 1,32'hDEADBEEF, 0,0,0);
    // reset mid-miss on 0x400, then refetch 0x004
    add(0,1,1,0,0, 32'h400, 0,            1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h400, 0,            1, 0,0,            1,1,32'h400);
    add(1,1,1,0,0, 32'h400, 0,            0, 0,0,            0,0,0);
    add(0,1,0,0,0, 32'h400, 0,            1, 0,0,            0,1,32'h0);
    add(0,1,1,0,0, 32'h004, 0,            1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h004, 0,            1, 0,0,            1,1,32'h004);
    add(0,1,1,0,1, 32'h004, 32'h44444444, 1, 0,0,            0,0,0);
    add(0,1,1,0,0, 32'h004, 0,            1, 1,32'h44444444, 0,0,0);
    add(0,1,1,0,0, 32'h200, 0,            1, 0,0,            0,0,0);
    add(0,1,1,1,0, 32'h200, 0,            1, 0,0,            0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].fv, vecs[i].clr, vecs[i].men, vecs[i].pc, vecs[i].din);
      #1;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d hit", i), {31'b0, hit}, {31'b0, vecs[i].e_hit});
        if (vecs[i].e_hit) check($sformatf("vec%0d inst", i), inst, vecs[i].e_inst);
        check($sformatf("vec%0d mem_valid", i), {31'b0, mem_valid}, {31'b0, vecs[i].e_mv});
        if (vecs[i].chk_ma) check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_ma);
      end
    end

    // Randomized traffic against the model
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r_rst, r_rdy, r_fv, r_clr, r_men, e_hit, e_mv;
      logic [31:0] r_pc, r_din;
      logic [7:0]  idx;
      @(posedge clk); #1;
      r_rst = ($urandom_range(0, 299) == 0);
      r_rdy = ($urandom_range(0, 7) != 0);
      r_fv  = ($urandom_range(0, 3) != 0);
      r_clr = ($urandom_range(0, 15) == 0);
      r_pc  = pcs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      r_din = $urandom;
      r_men = m_pend && r_rdy && (m_lat == 0);
      drive(r_rst, r_rdy, r_fv, r_clr, r_men, r_pc, r_din);
      #1;
      idx   = r_pc[9:2];
      e_hit = r_rdy && r_fv && m_v[idx] && (m_w[idx] == r_pc[31:2]);
      e_mv  = m_pend && !(r_rdy && (r_men || r_clr));
      if (!r_rst) begin
        check($sformatf("rnd%0d hit", cyc), {31'b0, hit}, {31'b0, e_hit});
        if (e_hit) check($sformatf("rnd%0d inst", cyc), inst, m_d[idx]);
        check($sformatf("rnd%0d mem_valid", cyc), {31'b0, mem_valid}, {31'b0, e_mv});
        if (e_mv) check($sformatf("rnd%0d mem_addr", cyc), mem_addr, m_pa);
      end
      if (r_rst) begin
        model_reset();
      end else if (r_rdy) begin
        if (m_pend) begin
          if (r_men) begin
            m_v[m_pa[9:2]] = 1;
            m_w[m_pa[9:2]] = m_pa[31:2];
            m_d[m_pa[9:2]] = r_din;
          end else if (m_lat > 0) begin
            m_lat--;
          end
          if (r_men || r_clr) m_pend = 0;
        end else if (r_fv && !e_hit && !r_clr) begin
          m_pend = 1;
          m_pa   = {r_pc[31:2], 2'b00};
          m_lat  = $urandom_range(0, 3);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
